// File: rtl/sdram_fifo_pkg.sv
// Shared constants and types for the SDRAM-side read FIFO.
// Depth, RAM read latency and output buffer size live here.
package sdram_fifo_pkg;

  localparam int FIFO_AW    = 8;
  localparam int FIFO_DEPTH = 256;
  localparam int RAM_RD_LAT = 2;
  localparam int OB_DEPTH   = 4;
  localparam int OCC_W      = 9;
  localparam int LEVEL_W    = 10;
  localparam int DATA_W     = 32;
  localparam int OB_AW      = 2;
  localparam int OB_CW      = 3;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [FIFO_AW-1:0] ptr_t;

endpackage

// File: rtl/sdram_fifo_outbuf.sv
// Small register FIFO that holds words returned from the RAM.
// Push and pop may coincide; clear empties it synchronously.
module sdram_fifo_outbuf
  import sdram_fifo_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  word_t            push_data,
  input  logic             pop,
  output word_t            head,
  output logic [OB_CW-1:0] count
);

  word_t             mem_q [OB_DEPTH];
  logic [OB_AW-1:0]  hd_q;
  logic [OB_AW-1:0]  tl_q;
  logic [OB_CW-1:0]  cnt_q;

  // Ring storage with head/tail pointers and an occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OB_DEPTH; i++) mem_q[i] <= '0;
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[tl_q] <= push_data;
        tl_q        <= tl_q + 1'b1;
      end
      if (pop) hd_q <= hd_q + 1'b1;
      cnt_q <= cnt_q + OB_CW'(push) - OB_CW'(pop);
    end
  end

  assign head  = mem_q[hd_q];
  assign count = cnt_q;

endmodule

// File: rtl/sdram_rdfifo_ctrl.sv
// Pointer, credit and prefetch control for a 256x32 RAM-backed FIFO.
// Reads are issued early so the output buffer streams one word per clock.
module sdram_rdfifo_ctrl
  import sdram_fifo_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [31:0]        wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [31:0]        rd_data,
  output logic [LEVEL_W-1:0] level,
  output logic               ram_wren_a,
  output logic [7:0]         ram_address_a,
  output logic [31:0]        ram_data_a,
  output logic               ram_wren_b,
  output logic [7:0]         ram_address_b,
  input  logic [31:0]        ram_q_b
);

  ptr_t                  wptr_q, wptr_d;
  ptr_t                  rptr_q, rptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [RAM_RD_LAT-1:0] iss_q, iss_d;

  logic [1:0]       inflight;
  logic [OB_CW-1:0] ob_cnt;
  logic             wr_acc;
  logic             rd_issue;
  logic             credit_ok;
  logic             ob_pop;

  assign inflight  = 2'($countones(iss_q));
  assign credit_ok = ({1'b0, inflight} + ob_cnt) < OB_CW'(OB_DEPTH);
  assign wr_ready  = (occ_q != OCC_W'(FIFO_DEPTH)) && !flush;
  assign wr_acc    = wr_valid && wr_ready && !reset;
  assign rd_issue  = !flush && (occ_q != '0) && credit_ok;
  assign rd_valid  = ob_cnt != '0;
  assign ob_pop    = rd_valid && rd_ready;

  assign ram_wren_a    = wr_acc;
  assign ram_address_a = wptr_q;
  assign ram_data_a    = wr_data;
  assign ram_wren_b    = 1'b0;
  assign ram_address_b = rptr_q;

  assign level = LEVEL_W'(occ_q) + LEVEL_W'(inflight)
               + LEVEL_W'(ob_cnt);

  // Next-state for pointers, unissued count and the issue pipeline.
  always_comb begin
    wptr_d = wptr_q + FIFO_AW'(wr_acc);
    rptr_d = rptr_q + FIFO_AW'(rd_issue);
    occ_d  = occ_q + OCC_W'(wr_acc) - OCC_W'(rd_issue);
    iss_d  = {iss_q[RAM_RD_LAT-2:0], rd_issue};
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
      iss_d  = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      iss_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      iss_q  <= iss_d;
    end
  end

  sdram_fifo_outbuf u_outbuf (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (iss_q[RAM_RD_LAT-1]),
    .push_data (ram_q_b),
    .pop       (ob_pop),
    .head      (rd_data),
    .count     (ob_cnt)
  );

endmodule
